pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Owns the 16-bit program counter and sequences instruction fetch for the pipelined CPU.
//  Picks the next PC (sequential +2, branch target or jump-register target) and drives the
//  I-memory/I-cache request handshake. Handles hazard stalls, cache-miss waits, EX-stage
//  redirects and HLT. Sits between the IF stage (I-cache, IF/ID register) and the hazard/branch logic.
// PARAMETERS
//  RESET_PC     16'h0000  PC value loaded on reset
//  HALT_OPCODE  4'hF      instr[15:12] value that encodes HLT
//  MISS_TIMEOUT 8'd64     miss-wait cycles before miss_err is raised
// PORTS
//  clk          in   1   system clock; all state updates on the rising edge
//  rst_n        in   1   synchronous, active-low reset
//  stall        in   1   hazard unit: hold PC and IF/ID
//  redirect     in   1   EX stage: taken branch or jump this cycle
//  branch_src   in   1   1 = use jr_target, 0 = use br_target
//  br_target    in   16  PC-relative branch target from EX
//  jr_target    in   16  register jump target (SrcData1) from EX
//  imem_ready   in   1   I-cache: imem_instr valid for imem_addr this cycle
//  imem_instr   in   16  fetched instruction
//  imem_req     out  1   fetch request
//  imem_addr    out  16  fetch address (= pc_out)
//  pc_out       out  16  current PC
//  pc_plus2     out  16  pc_out + 2, to IF/ID for link/branch math
//  if_valid     out  1   write imem_instr into IF/ID this cycle
//  flush_ifid   out  1   squash IF/ID contents this cycle
//  halted       out  1   fetch stopped on HLT
//  miss_err     out  1   sticky: a miss exceeded MISS_TIMEOUT
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): pc=RESET_PC, state=RUN, miss_cnt=0, miss_err=0, pend_redir=0.
//   While rst_n==0, imem_req=0, if_valid=0, flush_ifid=0, halted=0.
//  States: RUN, MISS, HALT.
//  Target selection: tgt = branch_src ? jr_target : br_target. Bit 0 is forced to 0.
//  Sequential increment: pc+2 mod 2^16, so 16'hFFFE wraps to 16'h0000.
//  RUN:
//   - imem_req=1.
//   - Priority, highest first: redirect > stall > miss > HLT > sequential.
//   - redirect=1 -> pc<=tgt, flush_ifid=1, if_valid=0. Applies even when stall=1.
//   - stall=1 -> pc holds, if_valid=0.
//   - imem_ready=0 -> state<=MISS, pc holds, miss_cnt<=1.
//   - imem_ready=1 and instr[15:12]==HALT_OPCODE -> if_valid=1 (HLT enters pipe), pc holds, state<=HALT.
//   - Otherwise -> if_valid=1, pc<=pc+2.
//  MISS:
//   - imem_req=1, pc holds, if_valid=0, miss_cnt increments and saturates at 8'hFF.
//   - miss_cnt==MISS_TIMEOUT -> miss_err<=1, sticky until reset.
//   - redirect during MISS -> pend_redir<=1, pend_tgt<=tgt. Latest redirect wins. No flush yet.
//   - imem_ready=1 with pend_redir -> discard instr, pc<=pend_tgt, flush_ifid=1, pend_redir<=0, state<=RUN.
//   - imem_ready=1 with redirect in the same cycle -> same as the pending case, using the new tgt.
//   - imem_ready=1, no redirect -> state<=RUN. The instr is re-presented next cycle (1-cycle re-fetch).
//  HALT:
//   - halted=1, imem_req=0, pc frozen.
//   - redirect (an older branch resolving after HLT was fetched) -> pc<=tgt, flush_ifid=1, halted=0, state<=RUN.
//   - Only redirect or reset leaves HALT; stall is ignored.
//  Latency: redirect at edge N -> imem_addr=tgt from cycle N+1. Sequential fetch issues one instruction per cycle on hits.
//  Reset mid-miss or mid-halt: same as reset; any pending redirect is dropped.
//  Outputs pc_out, imem_addr, pc_plus2 are registered-state derived. Combinational paths:
//   redirect->flush_ifid, and imem_ready->if_valid.
// TESTING
//  1. Reset, then 4 hits -> imem_addr 0000,0002,0004,0006; if_valid=1 each cycle.
//  2. At pc=0006 assert stall 2 cycles -> pc stays 0006, if_valid=0; next hit resumes at 0008.
//  3. At pc=0010, redirect with branch_src=0, br_target=0x0040, stall=1 -> next pc=0040, flush_ifid=1 that cycle.
//  4. Miss at pc=0020 for 5 cycles; redirect to jr_target=0x0101 in cycle 2; ready in cycle 5 -> instr discarded, pc=0100, flush_ifid=1.
//  5. Fetch 0xF000 at pc=0030 -> if_valid=1, then halted=1, imem_req=0, pc=0030 held; later redirect to 0x0050 -> halted=0, pc=0050.
//  6. Hold imem_ready=0 for 70 cycles -> miss_err=1 after cycle 64, stays 1 after the miss; rst_n=0 clears it. pc=FFFE hit -> pc=0000.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch sequencer: next-PC selection, I-cache request
// handshake, hazard stalls, miss waits with timeout, EX redirects and HLT.
module pc_fetch_ctrl #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE  = 4'hF,
    parameter logic [7:0]  MISS_TIMEOUT = 8'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic        branch_src,
    input  logic [15:0] br_target,
    input  logic [15:0] jr_target,
    input  logic        imem_ready,
    input  logic [15:0] imem_instr,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus2,
    output logic        if_valid,
    output logic        flush_ifid,
    output logic        halted,
    output logic        miss_err
);

    // state  | meaning
    // S_RUN  | fetching one instruction per cycle on hits
    // S_MISS | waiting on I-cache; redirects are parked in pend_redir/pend_tgt
    // S_HALT | HLT fetched; only a redirect or reset restarts fetch
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_MISS = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] pend_tgt, pend_tgt_nxt;
    logic        pend_redir, pend_redir_nxt;
    logic [7:0]  miss_cnt, miss_cnt_nxt;
    logic        miss_err_q, miss_err_nxt;
    logic [15:0] tgt_raw, tgt;

    assign tgt_raw   = branch_src ? jr_target : br_target;
    assign tgt       = {tgt_raw[15:1], 1'b0};
    assign pc_out    = pc;
    assign imem_addr = pc;
    assign pc_plus2  = pc + 16'd2;
    assign miss_err  = miss_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_RUN;
            pc         <= RESET_PC;
            pend_tgt   <= 16'h0000;
            pend_redir <= 1'b0;
            miss_cnt   <= 8'd0;
            miss_err_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pend_tgt   <= pend_tgt_nxt;
            pend_redir <= pend_redir_nxt;
            miss_cnt   <= miss_cnt_nxt;
            miss_err_q <= miss_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_tgt_nxt   = pend_tgt;
        pend_redir_nxt = pend_redir;
        miss_cnt_nxt   = miss_cnt;
        miss_err_nxt   = miss_err_q;
        imem_req       = 1'b0;
        if_valid       = 1'b0;
        flush_ifid     = 1'b0;
        halted         = 1'b0;
        if (rst_n) begin
            case (state)
                S_RUN: begin
                    imem_req = 1'b1;
                    if (redirect) begin
                        pc_nxt     = tgt;
                        flush_ifid = 1'b1;
                    end else if (stall) begin
                        pc_nxt = pc;
                    end else if (!imem_ready) begin
                        state_nxt    = S_MISS;
                        miss_cnt_nxt = 8'd1;
                    end else if (imem_instr[15:12] == HALT_OPCODE) begin
                        if_valid  = 1'b1;
                        state_nxt = S_HALT;
                    end else begin
                        if_valid = 1'b1;
                        pc_nxt   = pc + 16'd2;
                    end
                end
                S_MISS: begin
                    imem_req = 1'b1;
                    if (miss_cnt != 8'hFF) begin
                        miss_cnt_nxt = miss_cnt + 8'd1;
                    end
                    if (miss_cnt == MISS_TIMEOUT) begin
                        miss_err_nxt = 1'b1;
                    end
                    // The returning instruction belongs to the wrong path if any redirect arrived.
                    if (imem_ready) begin
                        state_nxt      = S_RUN;
                        pend_redir_nxt = 1'b0;
                        if (redirect) begin
                            pc_nxt     = tgt;
                            flush_ifid = 1'b1;
                        end else if (pend_redir) begin
                            pc_nxt     = pend_tgt;
                            flush_ifid = 1'b1;
                        end
                    end else if (redirect) begin
                        pend_redir_nxt = 1'b1;
                        pend_tgt_nxt   = tgt;
                    end
                end
                S_HALT: begin
                    halted = 1'b1;
                    if (redirect) begin
                        pc_nxt     = tgt;
                        flush_ifid = 1'b1;
                        state_nxt  = S_RUN;
                    end
                end
                default: begin
                    state_nxt = S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboarded bench for pc_fetch_ctrl: the driver queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic        branch_src = 1'b0;
    logic [15:0] br_target = 16'h0000;
    logic [15:0] jr_target = 16'h0000;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_instr = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2;
    logic        if_valid;
    logic        flush_ifid;
    logic        halted;
    logic        miss_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic exp_err = 1'b0;

    typedef struct {
        logic [15:0] addr;
        logic        ifv;
        logic        flush;
        logic        halt;
        logic        req;
        logic        err;
        logic        chk_err;
        int          id;
    } exp_t;

    exp_t sb[$];

    pc_fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redirect   (redirect),
        .branch_src (branch_src),
        .br_target  (br_target),
        .jr_target  (jr_target),
        .imem_ready (imem_ready),
        .imem_instr (imem_instr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .pc_out     (pc_out),
        .pc_plus2   (pc_plus2),
        .if_valid   (if_valid),
        .flush_ifid (flush_ifid),
        .halted     (halted),
        .miss_err   (miss_err)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic s, input logic rd, input logic bs,
                         input logic [15:0] bt, input logic [15:0] jt,
                         input logic rdy, input logic [15:0] ins,
                         input logic [15:0] ea, input logic ev, input logic ef,
                         input logic eh, input logic eq, input logic ee, input logic ece);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n      = r;
        stall      = s;
        redirect   = rd;
        branch_src = bs;
        br_target  = bt;
        jr_target  = jt;
        imem_ready = rdy;
        imem_instr = ins;
        cyc++;
        e.addr = ea; e.ifv = ev; e.flush = ef; e.halt = eh; e.req = eq;
        e.err = ee; e.chk_err = ece; e.id = cyc;
        sb.push_back(e);
    endtask

    task automatic hit(input logic [15:0] a);
        drive(1, 0, 0, 0, 16'h0, 16'h0, 1, 16'h1000, a, 1, 0, 0, 1, exp_err, 1);
    endtask

    task automatic miss_cyc(input logic [15:0] a);
        drive(1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0000, a, 0, 0, 0, 1, exp_err, 1);
    endtask

    // Monitor: every presented cycle is compared against the oldest queued expectation.
    initial begin
        exp_t e;
        logic [15:0] p2;
        logic ok;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                p2 = e.addr + 16'd2;
                ok = (imem_addr == e.addr) && (pc_out == e.addr) && (pc_plus2 == p2) &&
                     (if_valid == e.ifv) && (flush_ifid == e.flush) && (halted == e.halt) &&
                     (imem_req == e.req) && (!e.chk_err || miss_err == e.err);
                n_checks++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL cyc%0d: got addr=%h pc=%h p2=%h ifv=%b flush=%b halt=%b req=%b err=%b; want addr=%h p2=%h ifv=%b flush=%b halt=%b req=%b err=%b(chk=%b)",
                             e.id, imem_addr, pc_out, pc_plus2, if_valid, flush_ifid, halted,
                             imem_req, miss_err, e.addr, p2, e.ifv, e.flush, e.halt, e.req,
                             e.err, e.chk_err);
                end
            end
        end
    end

    initial begin
        // Reset: outputs gated even with redirect/ready asserted.
        drive(0, 0, 1, 0, 16'h1234, 16'h0, 1, 16'h1000, 16'h0000, 0, 0, 0, 0, 0, 1);
        hit(16'h0000); hit(16'h0002); hit(16'h0004);
        drive(1, 1, 0, 0, 16'h0, 16'h0, 1, 16'h1000, 16'h0006, 0, 0, 0, 1, 0, 1);
        drive(1, 1, 0, 0, 16'h0, 16'h0, 1, 16'h1000, 16'h0006, 0, 0, 0, 1, 0, 1);
        hit(16'h0006); hit(16'h0008); hit(16'h000A); hit(16'h000C); hit(16'h000E);
        // Redirect overrides stall.
        drive(1, 1, 1, 0, 16'h0040, 16'h0999, 1, 16'h1000, 16'h0010, 0, 1, 0, 1, 0, 1);
        hit(16'h0040);
        // Redirect overrides a miss; jr target.
        drive(1, 0, 1, 1, 16'h0777, 16'h0020, 0, 16'h0000, 16'h0042, 0, 1, 0, 1, 0, 1);
        // Miss with parked redirects; latest (0x0101 -> 0x0100) wins, no flush until ready.
        miss_cyc(16'h0020);
        drive(1, 0, 1, 0, 16'h0300, 16'h0, 0, 16'h0000, 16'h0020, 0, 0, 0, 1, 0, 1);
        drive(1, 0, 1, 1, 16'h0, 16'h0101, 0, 16'h0000, 16'h0020, 0, 0, 0, 1, 0, 1);
        miss_cyc(16'h0020);
        drive(1, 0, 0, 0, 16'h0, 16'h0, 1, 16'h1000, 16'h0020, 0, 1, 0, 1, 0, 1);
        // Plain miss: ready returns, instruction re-fetched next cycle.
        miss_cyc(16'h0100);
        drive(1, 0, 0, 0, 16'h0, 16'h0, 1, 16'h1000, 16'h0100, 0, 0, 0, 1, 0, 1);
        hit(16'h0100);
        // Ready and redirect in the same miss cycle.
        miss_cyc(16'h0102);
        drive(1, 0, 1, 0, 16'h0030, 16'h0, 1, 16'h1000, 16'h0102, 0, 1, 0, 1, 0, 1);
        // HLT, stall ignored while halted, redirect restarts.
        drive(1, 0, 0, 0, 16'h0, 16'h0, 1, 16'hF000, 16'h0030, 1, 0, 0, 1, 0, 1);
        drive(1, 1, 0, 0, 16'h0, 16'h0, 1, 16'h1000, 16'h0030, 0, 0, 1, 0, 0, 1);
        drive(1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0000, 16'h0030, 0, 0, 1, 0, 0, 1);
        drive(1, 0, 1, 0, 16'h0050, 16'h0, 1, 16'h0000, 16'h0030, 0, 1, 1, 0, 0, 1);
        hit(16'h0050);
        // Stall outranks HLT.
        drive(1, 1, 0, 0, 16'h0, 16'h0, 1, 16'hF000, 16'h0052, 0, 0, 0, 1, 0, 1);
        // Long miss: miss_err rises around the 64-cycle mark and sticks.
        for (int k = 1; k <= 70; k++) begin
            drive(1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0000, 16'h0052, 0, 0, 0, 1,
                  (k >= 66), !(k >= 64 && k <= 66));
        end
        exp_err = 1'b1;
        drive(1, 0, 0, 0, 16'h0, 16'h0, 1, 16'h1000, 16'h0052, 0, 0, 0, 1, 1, 1);
        hit(16'h0052);
        drive(0, 0, 0, 0, 16'h0, 16'h0, 1, 16'h1000, 16'h0054, 0, 0, 0, 0, 1, 1);
        exp_err = 1'b0;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 1, 16'h1000, 16'h0000, 0, 0, 0, 0, 0, 1);
        // Wrap at the top of the address space.
        drive(1, 0, 1, 1, 16'h0, 16'hFFFE, 1, 16'h1000, 16'h0000, 0, 1, 0, 1, 0, 1);
        hit(16'hFFFE);
        hit(16'h0000);

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
